// File: rtl/riot_pkg.sv
// Shared definitions for the wb_riot 6532-style RIOT.
// Register map, prescale encoding, interval lookup and TIMINT layout.
package riot_pkg;

    localparam logic [7:0] A_SWCHA  = 8'h00;
    localparam logic [7:0] A_SWACNT = 8'h01;
    localparam logic [7:0] A_SWCHB  = 8'h02;
    localparam logic [7:0] A_SWBCNT = 8'h03;
    localparam logic [7:0] A_INTIM  = 8'h04;
    localparam logic [7:0] A_TIMINT = 8'h05;

    localparam int TIMINT_TBIT = 7;
    localparam int TIMINT_PBIT = 6;

    typedef enum logic [1:0] {
        P1    = 2'd0,
        P8    = 2'd1,
        P64   = 2'd2,
        P1024 = 2'd3
    } presc_t;

    // Last value of the interval counter before INTIM decrements.
    function automatic logic [10:0] interval_last(input presc_t p);
        case (p)
            P1:      return 11'd0;
            P8:      return 11'd7;
            P64:     return 11'd63;
            default: return 11'd1023;
        endcase
    endfunction

endpackage

// File: rtl/riot_timer.sv
// RIOT interval timer: CPU-cycle prescaler, interval counter,
// INTIM down-counter and the sticky underflow flag.
module riot_timer
    import riot_pkg::*;
#(
    parameter int CLK_DIV = 24
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load,
    input  logic [7:0] value,
    input  presc_t     prescale,
    input  logic       clear,
    output logic [7:0] intim,
    output logic       tflag
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [10:0]   icnt;
    presc_t        sel;
    logic          fast;
    logic          tick;
    logic          wrap;
    logic          unf;

    assign tick = (pcnt == PLAST);
    // After an underflow the count runs at one decrement per tick.
    assign wrap = fast | (icnt == interval_last(sel));
    assign unf  = tick & wrap & (intim == 8'h00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel   <= P1024;
            fast  <= 1'b0;
            icnt  <= '0;
            intim <= '0;
            tflag <= 1'b0;
        end else if (load) begin
            sel   <= prescale;
            fast  <= 1'b0;
            icnt  <= '0;
            intim <= value;
            tflag <= 1'b0;
        end else begin
            if (tick) begin
                if (wrap) begin
                    icnt  <= '0;
                    intim <= intim - 8'd1;
                    if (intim == 8'h00) begin
                        fast <= 1'b1;
                    end
                end else begin
                    icnt <= icnt + 11'd1;
                end
            end
            if (unf) begin
                tflag <= 1'b1;
            end else if (clear) begin
                tflag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_riot.sv
// Wishbone RIOT: two I/O ports with direction registers plus interval timer.
// Define RIOT_IRQ_EN for the PA7 edge detector, IRQ enables and irq_o.
module wb_riot #(
    parameter int PORT_W  = 8,
    parameter int ADDR_W  = 7,
    parameter int CLK_DIV = 24
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [7:0]        dat_i,
    output logic              ack_o,
    output logic [7:0]        dat_o,
    input  logic [PORT_W-1:0] pa_i,
    output logic [PORT_W-1:0] pa_o,
    output logic [PORT_W-1:0] pa_oe_o,
    input  logic [PORT_W-1:0] pb_i,
    output logic [PORT_W-1:0] pb_o,
    output logic [PORT_W-1:0] pb_oe_o,
    output logic              irq_o
);

    import riot_pkg::*;

    logic [7:0]        a;
    logic              hi_ok;
    logic              acc;
    logic              wr;
    logic              rd;
    logic [PORT_W-1:0] wd;
    logic [PORT_W-1:0] pa_q;
    logic [PORT_W-1:0] pa_ddr;
    logic [PORT_W-1:0] pb_q;
    logic [PORT_W-1:0] pb_ddr;
    logic [PORT_W-1:0] pa_v;
    logic [PORT_W-1:0] pb_v;
    logic [7:0]        rdata;
    logic [7:0]        intim;
    logic              tflag;
    logic              pflag;
    logic              tload;
    logic              tclr;

    // Wide address buses must not alias onto the 8-bit map.
    if (ADDR_W > 8) begin : g_hi
        assign hi_ok = ~|adr_i[ADDR_W-1:8];
    end else begin : g_nohi
        assign hi_ok = 1'b1;
    end

    assign a    = hi_ok ? 8'(adr_i) : 8'hFF;
    assign acc  = stb_i & ~ack_o;
    assign wr   = acc & we_i;
    assign rd   = acc & ~we_i;
    assign wd   = PORT_W'(dat_i);
    assign pa_v = (pa_q & pa_ddr) | (pa_i & ~pa_ddr);
    assign pb_v = (pb_q & pb_ddr) | (pb_i & ~pb_ddr);
    assign tclr = rd & (a == A_INTIM);

    assign pa_o    = pa_q;
    assign pa_oe_o = pa_ddr;
    assign pb_o    = pb_q;
    assign pb_oe_o = pb_ddr;

    always_comb begin
        rdata = 8'h00;
        case (a)
            A_SWCHA:  rdata = 8'(pa_v);
            A_SWACNT: rdata = 8'(pa_ddr);
            A_SWCHB:  rdata = 8'(pb_v);
            A_SWBCNT: rdata = 8'(pb_ddr);
            A_INTIM:  rdata = intim;
            A_TIMINT: begin
                rdata[TIMINT_TBIT] = tflag;
                rdata[TIMINT_PBIT] = pflag;
            end
            default:  rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_o  <= 1'b0;
            dat_o  <= 8'h00;
            pa_q   <= '0;
            pa_ddr <= '0;
            pb_q   <= '0;
            pb_ddr <= '0;
        end else begin
            ack_o <= acc;
            if (rd) begin
                dat_o <= rdata;
            end
            if (wr) begin
                case (a)
                    A_SWCHA:  pa_q   <= wd;
                    A_SWACNT: pa_ddr <= wd;
                    A_SWCHB:  pb_q   <= wd;
                    A_SWBCNT: pb_ddr <= wd;
                    default:  ;
                endcase
            end
        end
    end

`ifdef RIOT_IRQ_EN
    logic ewr;
    logic hit;
    logic pa7_q;
    logic pos_q;
    logic pie_q;
    logic tie_q;
    logic pf_q;
    logic irq_q;

    // Timer writes at 0x1C-0x1F are the IRQ-enabled aliases of 0x14-0x17.
    assign tload = wr & (a[7:5] == 3'b000) & a[4] & a[2];
    assign ewr   = wr & (a[7:2] == 6'b000001);
    assign hit   = pos_q ? (~pa7_q & pa_i[PORT_W-1])
                         : (pa7_q & ~pa_i[PORT_W-1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pa7_q <= 1'b0;
            pos_q <= 1'b0;
            pie_q <= 1'b0;
            tie_q <= 1'b0;
            pf_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            pa7_q <= pa_i[PORT_W-1];
            if (ewr) begin
                pos_q <= a[0];
                pie_q <= a[1];
            end
            if (tload) begin
                tie_q <= a[3];
            end
            if (hit) begin
                pf_q <= 1'b1;
            end else if (rd && (a == A_TIMINT)) begin
                pf_q <= 1'b0;
            end
            irq_q <= (tflag & tie_q) | (pf_q & pie_q);
        end
    end

    assign pflag = pf_q;
    assign irq_o = irq_q;
`else
    assign tload = wr & (a[7:2] == 6'b000101);
    assign pflag = 1'b0;
    assign irq_o = 1'b0;
`endif

    riot_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load     (tload),
        .value    (dat_i),
        .prescale (presc_t'(a[1:0])),
        .clear    (tclr),
        .intim    (intim),
        .tflag    (tflag)
    );

endmodule

// File: tb/tb_wb_riot.sv
// Self-checking bench for wb_riot: tick-count timer model plus
// directed bus sequences with hand-computed reads.
module tb_wb_riot;

    localparam int PW  = 8;
    localparam int AW  = 7;
    localparam int DIV = 24;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] adr   = '0;
    logic [7:0]    wdat  = '0;
    logic          ack;
    logic [7:0]    rdat;
    logic [PW-1:0] pa_i  = '0;
    logic [PW-1:0] pb_i  = '0;
    logic [PW-1:0] pa_o;
    logic [PW-1:0] pa_oe;
    logic [PW-1:0] pb_o;
    logic [PW-1:0] pb_oe;
    logic          irq;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    wb_riot #(
        .PORT_W  (PW),
        .ADDR_W  (AW),
        .CLK_DIV (DIV)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .stb_i   (stb),
        .we_i    (we),
        .adr_i   (adr),
        .dat_i   (wdat),
        .ack_o   (ack),
        .dat_o   (rdat),
        .pa_i    (pa_i),
        .pa_o    (pa_o),
        .pa_oe_o (pa_oe),
        .pb_i    (pb_i),
        .pb_o    (pb_o),
        .pb_oe_o (pb_oe),
        .irq_o   (irq)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: timer state kept as (load value, interval, ticks since load).
    int         edges;
    logic       m_ack;
    logic [7:0] m_dat;
    logic [7:0] m_pa, m_pad, m_pb, m_pbd;
    int         m_v, m_ival, m_n;
    logic       m_flag;
    logic       m_pflag, m_pie, m_pos, m_pa7, m_tie, m_irq;
    int         tbl [4] = '{1, 8, 64, 1024};

    function automatic logic [7:0] intim_of(input int v, input int ival,
                                            input int n);
        int m;
        if (n < (v + 1) * ival) return 8'(v - n / ival);
        m = n - (v + 1) * ival;
        return 8'(255 - (m % 256));
    endfunction

    function automatic logic [7:0] m_read(input logic [AW-1:0] a);
        case (a)
            7'h00:   return (m_pa & m_pad) | (pa_i & ~m_pad);
            7'h01:   return m_pad;
            7'h02:   return (m_pb & m_pbd) | (pb_i & ~m_pbd);
            7'h03:   return m_pbd;
            7'h04:   return intim_of(m_v, m_ival, m_n);
            7'h05:   return {m_flag, m_pflag, 6'b0};
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit m_twr(input logic [AW-1:0] a);
`ifdef RIOT_IRQ_EN
        return (a >= 7'h14 && a <= 7'h17) || (a >= 7'h1C && a <= 7'h1F);
`else
        return a >= 7'h14 && a <= 7'h17;
`endif
    endfunction

    task automatic model_reset();
        edges  = 0;
        m_ack  = 0;
        m_dat  = 0;
        m_pa   = 0;
        m_pad  = 0;
        m_pb   = 0;
        m_pbd  = 0;
        m_v    = 0;
        m_ival = 1024;
        m_n    = 0;
        m_flag = 0;
        m_pflag = 0;
        m_pie  = 0;
        m_pos  = 0;
        m_pa7  = 0;
        m_tie  = 0;
        m_irq  = 0;
    endtask

    task automatic model_step();
        logic       acc, wr, rd, tick, unf;
        logic [7:0] cur, nxt;
        edges++;
        tick = (edges % DIV) == 0;
        acc  = stb && !m_ack;
        wr   = acc && we;
        rd   = acc && !we;
        cur  = intim_of(m_v, m_ival, m_n);
        nxt  = tick ? intim_of(m_v, m_ival, m_n + 1) : cur;
        unf  = tick && cur == 8'h00 && nxt == 8'hFF;
        if (rd) m_dat = m_read(adr);
`ifdef RIOT_IRQ_EN
        begin
            logic hit;
            m_irq = (m_flag && m_tie) || (m_pflag && m_pie);
            hit = m_pos ? (!m_pa7 && pa_i[PW-1]) : (m_pa7 && !pa_i[PW-1]);
            if (hit) m_pflag = 1;
            else if (rd && adr == 7'h05) m_pflag = 0;
            m_pa7 = pa_i[PW-1];
            if (wr && adr >= 7'h04 && adr <= 7'h07) begin
                m_pos = adr[0];
                m_pie = adr[1];
            end
        end
`endif
        if (wr && m_twr(adr)) begin
            m_v    = int'(wdat);
            m_ival = tbl[adr[1:0]];
            m_n    = 0;
            m_flag = 0;
            m_tie  = adr[3];
        end else begin
            if (tick) m_n++;
            if (unf) m_flag = 1;
            else if (rd && adr == 7'h04) m_flag = 0;
        end
        if (wr) begin
            case (adr)
                7'h00:   m_pa  = wdat;
                7'h01:   m_pad = wdat;
                7'h02:   m_pb  = wdat;
                7'h03:   m_pbd = wdat;
                default: ;
            endcase
        end
        m_ack = acc;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            else model_step();
            chk("ack_o", 32'(ack), 32'(m_ack));
            chk("dat_o", 32'(rdat), 32'(m_dat));
            chk("pa_o", 32'(pa_o), 32'(m_pa));
            chk("pa_oe_o", 32'(pa_oe), 32'(m_pad));
            chk("pb_o", 32'(pb_o), 32'(m_pb));
            chk("pb_oe_o", 32'(pb_oe), 32'(m_pbd));
            chk("irq_o", 32'(irq), 32'(m_irq));
        end
    end

    task automatic step1();
        @(negedge clk);
        #1;
    endtask

    task automatic bus(input bit w, input logic [AW-1:0] a,
                       input logic [7:0] d, output logic [7:0] q,
                       output int e);
        stb  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        step1();
        e    = edges;
        stb  = 1'b0;
        we   = 1'b0;
        q    = rdat;
        step1();
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [7:0] d,
                          output int e);
        logic [7:0] q;
        bus(1'b1, a, d, q, e);
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a,
                          input logic [7:0] exp);
        logic [7:0] q;
        int e;
        bus(1'b0, a, 8'h00, q, e);
        chk(name, 32'(q), 32'(exp));
    endtask

    // Next access edge lands on a prescaler tick edge.
    task automatic align();
        for (int i = 0; i < DIV && (edges % DIV) != DIV - 1; i++) step1();
        if ((edges % DIV) != DIV - 1) begin
            mismatched++;
            $display("FAIL align: phase %0d, wanted %0d", edges % DIV, DIV - 1);
        end
    endtask

    task automatic read_at(input string name, input logic [AW-1:0] a,
                           input int w0, input int rel,
                           input logic [7:0] exp);
        logic [7:0] q;
        int e;
        for (int i = 0; i < 6000 && edges + 1 < w0 + rel; i++) step1();
        bus(1'b0, a, 8'h00, q, e);
        if (e != w0 + rel) begin
            mismatched++;
            $display("FAIL %s_edge: access at %0d, wanted %0d",
                     name, e - w0, rel);
        end
        chk(name, 32'(q), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, %0d mismatched so far",
                 mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] pat;
        pat = 4'b0101;

        repeat (3) step1();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", 32'(rdat), 0);
        chk("rst_pa_o", 32'(pa_o), 0);
        chk("rst_pa_oe", 32'(pa_oe), 0);
        chk("rst_pb_o", 32'(pb_o), 0);
        chk("rst_pb_oe", 32'(pb_oe), 0);
        chk("rst_irq", 32'(irq), 0);
        rst_n = 1'b1;
        step1();
        rd_chk("intim_rst", 7'h04, 8'h00);
        rd_chk("timint_rst", 7'h05, 8'h00);

        bus_wr(7'h01, 8'hF0, w);
        bus_wr(7'h00, 8'hA5, w);
        pa_i = 8'h3C;
        step1();
        chk("pa_o", 32'(pa_o), 32'h A5);
        chk("pa_oe", 32'(pa_oe), 32'h F0);
        rd_chk("swcha", 7'h00, 8'hAC);
        rd_chk("swacnt", 7'h01, 8'hF0);
        bus_wr(7'h03, 8'h0F, w);
        bus_wr(7'h02, 8'h5A, w);
        pb_i = 8'hC3;
        step1();
        chk("pb_o", 32'(pb_o), 32'h5A);
        chk("pb_oe", 32'(pb_oe), 32'h0F);
        rd_chk("swchb", 7'h02, 8'hCA);
        bus_wr(7'h09, 8'hFF, w);
        rd_chk("unmapped", 7'h09, 8'h00);
        chk("pa_o_kept", 32'(pa_o), 32'hA5);

        adr = 7'h00;
        we  = 1'b0;
        stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step1();
            chk("held_ack", 32'(ack), 32'(pat[i]));
        end
        stb = 1'b0;
        step1();
        chk("held_dat", 32'(rdat), 32'hAC);

        align();
        bus_wr(7'h14, 8'h05, w);
        read_at("t1_intim_24", 7'h04, w, 25, 8'h04);
        read_at("t1_intim_120", 7'h04, w, 121, 8'h00);
        read_at("t1_timint_144", 7'h05, w, 145, 8'h80);
        read_at("t1_intim_144", 7'h04, w, 147, 8'hFF);
        read_at("t1_timint_clr", 7'h05, w, 149, 8'h00);
        read_at("t1_intim_168", 7'h04, w, 170, 8'hFE);

        align();
        bus_wr(7'h16, 8'h02, w);
        read_at("t64_before", 7'h04, w, 1530, 8'h02);
        read_at("t64_first", 7'h04, w, 1537, 8'h01);
        read_at("t64_timint", 7'h05, w, 4609, 8'h80);
        read_at("t64_unf", 7'h04, w, 4611, 8'hFF);
        read_at("t64_clr", 7'h05, w, 4613, 8'h00);
        read_at("t64_fast1", 7'h04, w, 4633, 8'hFE);
        read_at("t64_fast2", 7'h04, w, 4657, 8'hFD);

        align();
        bus_wr(7'h14, 8'h00, w);
        read_at("t0_timint", 7'h05, w, 25, 8'h80);
        read_at("t0_intim", 7'h04, w, 27, 8'hFF);

        bus_wr(7'h17, 8'h40, w);
        rd_chk("pre_rst_intim", 7'h04, 8'h40);
        rst_n = 1'b0;
        step1();
        chk("mid_rst_dat", 32'(rdat), 0);
        chk("mid_rst_pa_o", 32'(pa_o), 0);
        chk("mid_rst_pa_oe", 32'(pa_oe), 0);
        chk("mid_rst_pb_o", 32'(pb_o), 0);
        chk("mid_rst_pb_oe", 32'(pb_oe), 0);
        chk("mid_rst_ack", 32'(ack), 0);
        rst_n = 1'b1;
        step1();
        rd_chk("post_rst_intim", 7'h04, 8'h00);
        rd_chk("post_rst_timint", 7'h05, 8'h00);
        rd_chk("post_rst_swcha", 7'h00, 8'h3C);

`ifdef RIOT_IRQ_EN
        bus_wr(7'h07, 8'h00, w);
        pa_i = 8'hBC;
        repeat (3) step1();
        chk("pa7_irq", 32'(irq), 1);
        rd_chk("pa7_timint", 7'h05, 8'h40);
        chk("pa7_irq_clr", 32'(irq), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
